nco_sweep_ctrl: RTL and testbench
=================================

Name: nco_sweep_ctrl

Overview:
- Sequencer that drives the NCO frequency control word through a programmable linear frequency sweep (chirp/stepped tone): start frequency, stop frequency, step size, dwell time per step.
- Sits directly upstream of the NCO: ctrl output feeds the NCO ctrl input; optional nco_rst feeds the NCO rst so that phase is aligned at sweep start.
- Start/busy/done handshake toward the system controller; single-shot or continuous repeat.

Parameters:
N, 32, width of frequency control word (matches NCO N)
DW, 16, width of dwell counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  1-cycle request; samples cfg_* when idle
abort  input  1  stop sweep immediately
cfg_start  input  N  first frequency word
cfg_stop  input  N  last frequency word
cfg_step  input  N  unsigned step magnitude
cfg_dwell  input  DW  cycles per step minus 1
cfg_repeat  input  1  1 = restart at cfg_start after final step
ctrl  output  N  frequency control word to NCO
busy  output  1  sweep in progress
done  output  1  1-cycle pulse at sweep completion
wrap  output  1  1-cycle pulse when repeat restarts at start frequency
nco_rst  output  1  NCO phase reset pulse (see Optional Feature)

Behaviour:
- One clock, synchronous active-high reset. Reset values: ctrl=0, busy=0, done=0, wrap=0, nco_rst=0, FSM=IDLE, dwell counter=0.
- FSM states: IDLE, DWELL, DONE.
- IDLE: start=1 and abort=0 -> latch cfg_* into shadow registers; direction up if cfg_stop >= cfg_start, else down; next cycle ctrl=cfg_start, busy=1, dwell counter=cfg_dwell, state DWELL. start in the same cycle as abort is ignored. cfg_* changes while busy have no effect.
- DWELL: counter decrements each cycle; each ctrl value is held for exactly cfg_dwell+1 cycles. When counter==0:
  - ctrl != stop: next = ctrl+step (up) or ctrl-step (down), computed in N+1 bits; clamp to stop if next overshoots stop (up: next > stop or carry out; down: borrow or next < stop). ctrl<=next, counter reloaded.
  - ctrl == stop, repeat=0: state DONE.
  - ctrl == stop, repeat=1: ctrl<=shadow start, counter reloaded, wrap=1 for that cycle.
- cfg_step==0: treated as a jump straight to stop (sequence start, stop); start==stop gives a single dwell.
- DONE (one cycle): busy=0, done=1, ctrl holds the stop value; then IDLE. A start in the DONE cycle is ignored; it must be issued in IDLE.
- start while busy: ignored, no effect.
- abort in any non-IDLE state: next cycle state IDLE, busy=0, ctrl=0, no done pulse, no wrap pulse. abort in IDLE: no effect beyond blocking start.
- Latency: start sampled at edge k -> first ctrl value visible from cycle k+1.
- rst mid-sweep: all outputs return to reset values on the next edge; shadow config discarded.

Optional Feature:
- Macro SWEEP_PHASE_RST_EN.
- Defined: nco_rst=1 for exactly one cycle, in the cycle before ctrl first shows cfg_start (the start-acceptance edge), and for one cycle coinciding with each wrap pulse, so the NCO phase restarts at 0 for every sweep pass.
- Undefined: nco_rst tied to 0; NCO phase runs continuously across steps and passes.

Test Plan:
- Up sweep: start=100, stop=130, step=10, dwell=2, repeat=0, start pulse at cycle 0 -> ctrl=100 (cycles 1-3), 110 (4-6), 120 (7-9), 130 (10-12); cycle 13: busy=0, done=1, ctrl stays 130; cycle 14: done=0.
- Clamp and down sweep: start=100, stop=125, step=10, dwell=2 -> 100,110,120,125, 3 cycles each. Then start=130, stop=100, step=10, dwell=0 -> 130,120,110,100, 1 cycle each, then done.
- Overflow clamp: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20, dwell=0 -> ctrl=0xFFFFFFF0 then 0xFFFFFFFF (no wrap to small value), then done.
- Repeat: start=0, stop=20, step=10, dwell=1, repeat=1 -> 0,0,10,10,20,20,0,... with wrap=1 in the cycle ctrl returns to 0; never done; with SWEEP_PHASE_RST_EN, nco_rst=1 at the start-acceptance edge and in each wrap cycle.
- Abort/ignored start: abort asserted mid-dwell at ctrl=110 -> next cycle ctrl=0, busy=0, no done. A start pulse while busy, or in the same cycle as abort, leaves the sequence unchanged.
- Reset mid-sweep: rst=1 during the 120 step -> next cycle ctrl=0, busy=0, done=0, wrap=0, nco_rst=0; a subsequent start runs the full sequence from cfg_start.

Source files
------------

// File: rtl/nco_sweep_ctrl_if.sv
// Sweep controller bus: start/abort request, sweep configuration,
// and the frequency word / status returned toward the NCO and system.
//   master: system side (drives start, abort, cfg_*; observes results)
//   slave : nco_sweep_ctrl (drives ctrl, busy, done, wrap, nco_rst)
interface nco_sweep_ctrl_if #(
    parameter int N  = 32,
    parameter int DW = 16
);
    logic          start;
    logic          abort;
    logic [N-1:0]  cfg_start;
    logic [N-1:0]  cfg_stop;
    logic [N-1:0]  cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic          cfg_repeat;
    logic [N-1:0]  ctrl;
    logic          busy;
    logic          done;
    logic          wrap;
    logic          nco_rst;

    modport master (
        output start, abort, cfg_start, cfg_stop,
        output cfg_step, cfg_dwell, cfg_repeat,
        input  ctrl, busy, done, wrap, nco_rst
    );

    modport slave (
        input  start, abort, cfg_start, cfg_stop,
        input  cfg_step, cfg_dwell, cfg_repeat,
        output ctrl, busy, done, wrap, nco_rst
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding an NCO control word.
// Ports: clk, rst (sync, active high), bus (nco_sweep_ctrl_if.slave):
//   start/abort/cfg_* in; ctrl word, busy, done, wrap, nco_rst out.
// Macro SWEEP_PHASE_RST_EN: pulse nco_rst at sweep start and every wrap;
// when undefined nco_rst is tied low.
module nco_sweep_ctrl #(
    parameter int N  = 32,
    parameter int DW = 16
) (
    input logic              clk,
    input logic              rst,
    nco_sweep_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  ctrl_q, ctrl_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  start_q, start_d;
    logic [N-1:0]  stop_q, stop_d;
    logic [N-1:0]  step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          rep_q, rep_d;
    logic          up_q, up_d;
    logic          wrap_q, wrap_d;

    logic          accept;
    logic [N:0]    sum;
    logic [N:0]    dif;
    logic [N-1:0]  nxt;

    assign accept = (state_q == S_IDLE) && bus.start && !bus.abort;

    // Next step value; the extra MSB flags carry (up) or borrow (down)
    // so an overshoot past either end of the word clamps to stop.
    always_comb begin
        sum = {1'b0, ctrl_q} + {1'b0, step_q};
        dif = {1'b0, ctrl_q} - {1'b0, step_q};
        nxt = stop_q;
        if (step_q != '0) begin
            if (up_q) begin
                if (!sum[N] && (sum[N-1:0] <= stop_q))
                    nxt = sum[N-1:0];
            end else begin
                if (!dif[N] && (dif[N-1:0] >= stop_q))
                    nxt = dif[N-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        rep_d   = rep_q;
        up_d    = up_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    start_d = bus.cfg_start;
                    stop_d  = bus.cfg_stop;
                    step_d  = bus.cfg_step;
                    dwell_d = bus.cfg_dwell;
                    rep_d   = bus.cfg_repeat;
                    up_d    = bus.cfg_stop >= bus.cfg_start;
                    ctrl_d  = bus.cfg_start;
                    cnt_d   = bus.cfg_dwell;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (bus.abort) begin
                    ctrl_d  = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (ctrl_q != stop_q) begin
                    ctrl_d = nxt;
                    cnt_d  = dwell_q;
                end else if (rep_q) begin
                    ctrl_d = start_q;
                    cnt_d  = dwell_q;
                    wrap_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (bus.abort)
                    ctrl_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            cnt_q   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            rep_q   <= 1'b0;
            up_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            rep_q   <= rep_d;
            up_q    <= up_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.ctrl = ctrl_q;
    assign bus.busy = (state_q == S_DWELL);
    assign bus.done = (state_q == S_DONE);
    assign bus.wrap = wrap_q;

`ifdef SWEEP_PHASE_RST_EN
    // High in the acceptance cycle so the NCO is reset on the same edge
    // that loads the first word, and alongside every wrap pulse.
    assign bus.nco_rst = (accept && !rst) || wrap_q;
`else
    assign bus.nco_rst = 1'b0;
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: table of sweeps plus
// hand-written abort / repeat / reset sequences, scoreboard-compared.
module tb_nco_sweep_ctrl;
    localparam int N  = 32;
    localparam int DW = 16;
`ifdef SWEEP_PHASE_RST_EN
    localparam bit PH = 1'b1;
`else
    localparam bit PH = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] ctrl;
        logic         busy;
        logic         done;
        logic         wrap;
        logic         nr;
    } exp_t;

    typedef struct {
        logic s;
        logic a;
        logic r;
    } stim_t;

    typedef struct {
        logic [N-1:0]        st;
        logic [N-1:0]        sp;
        logic [N-1:0]        stp;
        logic [DW-1:0]       dw;
        int                  n;
        logic [3:0][N-1:0]   v;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    logic [N-1:0] m_ctrl;
    exp_t  exp_q[$];
    stim_t stim_q[$];
    vec_t  tbl[7];

    nco_sweep_ctrl_if #(.N(N), .DW(DW)) bus ();

    nco_sweep_ctrl #(.N(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic [N-1:0] c, logic b, logic d,
                                logic w, logic n);
        exp_t e;
        e.ctrl = c;
        e.busy = b;
        e.done = d;
        e.wrap = w;
        e.nr   = n;
        return e;
    endfunction

    function automatic stim_t ms(logic s, logic a, logic r);
        stim_t t;
        t.s = s;
        t.a = a;
        t.r = r;
        return t;
    endfunction

    function automatic vec_t mkv(logic [N-1:0] st, logic [N-1:0] sp,
                                 logic [N-1:0] stp, logic [DW-1:0] dw,
                                 int n, logic [N-1:0] a0,
                                 logic [N-1:0] a1, logic [N-1:0] a2,
                                 logic [N-1:0] a3);
        vec_t t;
        t.st   = st;
        t.sp   = sp;
        t.stp  = stp;
        t.dw   = dw;
        t.n    = n;
        t.v[0] = a0;
        t.v[1] = a1;
        t.v[2] = a2;
        t.v[3] = a3;
        return t;
    endfunction

    task automatic chk(string nm, logic [N-1:0] got, logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, got, exp);
        end
    endtask

    task automatic set_cfg(logic [N-1:0] st, logic [N-1:0] sp,
                           logic [N-1:0] stp, logic [DW-1:0] dw,
                           logic rp);
        bus.cfg_start  = st;
        bus.cfg_stop   = sp;
        bus.cfg_step   = stp;
        bus.cfg_dwell  = dw;
        bus.cfg_repeat = rp;
    endtask

    // Drive each queued stimulus for one cycle (starting at a negedge),
    // compare against the next scoreboard entry, then advance a cycle.
    task automatic run_q();
        stim_t s;
        exp_t  e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            bus.start = s.s;
            bus.abort = s.a;
            rst       = s.r;
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard empty at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ctrl", bus.ctrl, e.ctrl);
                chk("busy", {31'd0, bus.busy}, {31'd0, e.busy});
                chk("done", {31'd0, bus.done}, {31'd0, e.done});
                chk("wrap", {31'd0, bus.wrap}, {31'd0, e.wrap});
                chk("nco_rst", {31'd0, bus.nco_rst}, {31'd0, e.nr});
            end
            @(negedge clk);
            cyc++;
            // Config must be ignored once a sweep is running.
            if (s.s)
                set_cfg($urandom, $urandom, $urandom, 16'($urandom), 1'b1);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard leftover %0d entries", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_vec(vec_t v, bit start_in_done);
        logic [N-1:0] last;
        last = v.v[v.n-1];
        set_cfg(v.st, v.sp, v.stp, v.dw, 1'b0);
        stim_q.push_back(ms(1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(m_ctrl, 1'b0, 1'b0, 1'b0, PH));
        for (int i = 0; i < v.n; i++) begin
            for (int j = 0; j <= int'(v.dw); j++) begin
                stim_q.push_back(ms(1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(v.v[i], 1'b1, 1'b0, 1'b0, 1'b0));
            end
        end
        stim_q.push_back(ms(start_in_done, 1'b0, 1'b0));
        exp_q.push_back(mk(last, 1'b0, 1'b1, 1'b0, 1'b0));
        stim_q.push_back(ms(1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(last, 1'b0, 1'b0, 1'b0, 1'b0));
        m_ctrl = last;
        run_q();
    endtask

    initial begin
        logic w;
        tbl[0] = mkv(32'd100, 32'd130, 32'd10, 16'd2, 4,
                     32'd100, 32'd110, 32'd120, 32'd130);
        tbl[1] = mkv(32'd100, 32'd125, 32'd10, 16'd2, 4,
                     32'd100, 32'd110, 32'd120, 32'd125);
        tbl[2] = mkv(32'd130, 32'd100, 32'd10, 16'd0, 4,
                     32'd130, 32'd120, 32'd110, 32'd100);
        tbl[3] = mkv(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 2,
                     32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        tbl[4] = mkv(32'd50, 32'd90, 32'd0, 16'd1, 2,
                     32'd50, 32'd90, 32'd0, 32'd0);
        tbl[5] = mkv(32'd70, 32'd70, 32'd5, 16'd1, 1,
                     32'd70, 32'd0, 32'd0, 32'd0);
        tbl[6] = mkv(32'd5, 32'd0, 32'd10, 16'd0, 2,
                     32'd5, 32'd0, 32'd0, 32'd0);

        checks    = 0;
        errors    = 0;
        cyc       = 0;
        m_ctrl    = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Reset state
        stim_q.push_back(ms(1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
        run_q();

        // Table of single-shot sweeps; first one also tries a start
        // during the DONE cycle, which must be ignored.
        foreach (tbl[i])
            run_vec(tbl[i], i == 0);

        // Continuous repeat, aborted in the third pass
        set_cfg(32'd0, 32'd20, 32'd10, 16'd1, 1'b1);
        stim_q.push_back(ms(1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(m_ctrl, 1'b0, 1'b0, 1'b0, PH));
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 2; j++) begin
                    if (!(p == 2 && k > 0)) begin
                        w = (p > 0 && k == 0 && j == 0);
                        stim_q.push_back(ms(1'b0, p == 2 && j == 1, 1'b0));
                        exp_q.push_back(mk(32'(10 * k), 1'b1, 1'b0,
                                           w, PH & w));
                    end
                end
            end
        end
        stim_q.push_back(ms(1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_ctrl = '0;
        run_q();

        // Abort at 110, start while busy, start+abort in idle
        set_cfg(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
        stim_q.push_back(ms(1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(m_ctrl, 1'b0, 1'b0, 1'b0, PH));
        for (int j = 0; j < 3; j++) begin
            stim_q.push_back(ms(1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(32'd100, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        stim_q.push_back(ms(1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(32'd110, 1'b1, 1'b0, 1'b0, 1'b0));
        stim_q.push_back(ms(1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(32'd110, 1'b1, 1'b0, 1'b0, 1'b0));
        stim_q.push_back(ms(1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
        stim_q.push_back(ms(1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
        stim_q.push_back(ms(1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_ctrl = '0;
        run_q();

        // Reset during the 120 step, then a full sweep afterwards
        set_cfg(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
        stim_q.push_back(ms(1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(m_ctrl, 1'b0, 1'b0, 1'b0, PH));
        for (int j = 0; j < 6; j++) begin
            stim_q.push_back(ms(1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(j < 3 ? 32'd100 : 32'd110,
                               1'b1, 1'b0, 1'b0, 1'b0));
        end
        stim_q.push_back(ms(1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(32'd120, 1'b1, 1'b0, 1'b0, 1'b0));
        stim_q.push_back(ms(1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_ctrl = '0;
        run_q();
        run_vec(tbl[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
